// File: rtl/ftdi_tx_pkg.sv
// Shared types and helpers for the FT245 host-bound frame transmitter.
// CRC8_POLY and crc8_byte serve the FTDI_TX_CRC_EN build of ftdi_tx_framer.
package ftdi_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_TAG,
        ST_LEN,
        ST_DLO,
        ST_DHI,
        ST_CHK
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    // CRC-8, MSB-first, one whole byte folded in per call
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ftdi_tx_framer_if.sv
// Fabric-side frame/stream handshakes and FT245 write-side bus of the framer.
// master = the framer itself, slave = fabric plus FTDI/arbiter environment.
interface ftdi_tx_framer_if;
    logic        frm_start;
    logic [7:0]  frm_len;
    logic [7:0]  frm_tag;
    logic        frm_busy;
    logic        frm_done;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic        ft_txe_n;
    logic        ft_wr_n;
    logic [7:0]  ft_d_out;
    logic        ft_d_oe;

    modport master (
        input  frm_start, frm_len, frm_tag, s_valid, s_data, bus_gnt, ft_txe_n,
        output frm_busy, frm_done, s_ready, bus_req, ft_wr_n, ft_d_out, ft_d_oe
    );

    modport slave (
        output frm_start, frm_len, frm_tag, s_valid, s_data, bus_gnt, ft_txe_n,
        input  frm_busy, frm_done, s_ready, bus_req, ft_wr_n, ft_d_out, ft_d_oe
    );
endinterface

// File: rtl/ftdi_tx_fifo.sv
// Single-clock show-ahead word FIFO: rd_data always shows the oldest entry.
// Writes are dropped when full, reads when empty; push and pop may coincide.
module ftdi_tx_fifo #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          push, pop;

    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign full    = cnt_q[AW];
    assign empty   = (cnt_q == '0);
    assign rd_data = mem[rp_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp_q] <= wr_data;
    end
endmodule

// File: rtl/ftdi_tx_framer.sv
// FT245 sync-FIFO transmitter: frames words as SYNC, TAG, LEN, data (lo,hi), CHECK.
// CHECK is a two's-complement sum by default, CRC-8 when FTDI_TX_CRC_EN is defined.
module ftdi_tx_framer
    import ftdi_tx_pkg::*;
#(
    parameter int         FIFO_AW   = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input logic              ft_clk,
    input logic              reset_n,
    ftdi_tx_framer_if.master io
);
`ifdef FTDI_TX_CRC_EN
    function automatic logic [7:0] acc_upd(input logic [7:0] a, input logic [7:0] b);
        return crc8_byte(a, b);
    endfunction
    function automatic logic [7:0] chk_of(input logic [7:0] a);
        return a;
    endfunction
`else
    function automatic logic [7:0] acc_upd(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction
    function automatic logic [7:0] chk_of(input logic [7:0] a);
        return 8'd0 - a;
    endfunction
`endif

    tx_state_e   state_q, state_d;
    logic [7:0]  d_q, d_d;
    logic [7:0]  tag_q, len_q, acc_q;
    logic [8:0]  cnt_q;
    logic        lo_valid_q, done_q;
    logic        byte_avail, accept, start_ok, last_word, busy;
    logic [15:0] fifo_head;
    logic        fifo_full, fifo_empty, fifo_pop;

    ftdi_tx_fifo #(.AW(FIFO_AW), .DW(16)) u_fifo (
        .clk     (ft_clk),
        .rst_n   (reset_n),
        .wr_en   (io.s_valid),
        .wr_data (io.s_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign busy      = (state_q != ST_IDLE);
    assign start_ok  = io.frm_start & ~done_q;
    assign last_word = (cnt_q == 9'd1);
    assign accept    = byte_avail & io.bus_gnt & ~io.ft_txe_n;
    assign fifo_pop  = accept & (state_q == ST_DLO);

    // DLO also needs d_q to have been loaded from a non-empty head (lo_valid_q)
    always_comb begin
        byte_avail = 1'b1;
        case (state_q)
            ST_IDLE: byte_avail = 1'b0;
            ST_DLO:  byte_avail = lo_valid_q & ~fifo_empty;
            default: byte_avail = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_SYNC;
            ST_SYNC: if (accept)   state_d = ST_TAG;
            ST_TAG:  if (accept)   state_d = ST_LEN;
            ST_LEN:  if (accept)   state_d = ST_DLO;
            ST_DLO:  if (accept)   state_d = ST_DHI;
            ST_DHI:  if (accept)   state_d = last_word ? ST_CHK : ST_DLO;
            ST_CHK:  if (accept)   state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Output byte register is preloaded with the next state's byte on acceptance
    always_comb begin
        d_d = d_q;
        case (state_q)
            ST_IDLE: d_d = start_ok ? SYNC_BYTE : 8'h00;
            ST_SYNC: if (accept) d_d = tag_q;
            ST_TAG:  if (accept) d_d = len_q;
            ST_LEN:  if (accept) d_d = fifo_head[7:0];
            ST_DLO:  d_d = accept ? fifo_head[15:8] : fifo_head[7:0];
            ST_DHI:  if (accept) d_d = last_word ? chk_of(acc_upd(acc_q, d_q)) : fifo_head[7:0];
            ST_CHK:  if (accept) d_d = 8'h00;
            default: d_d = 8'h00;
        endcase
    end

    always_ff @(posedge ft_clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge ft_clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q        <= '0;
            tag_q      <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            lo_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            d_q        <= d_d;
            lo_valid_q <= (state_d == ST_DLO) & ~fifo_empty;
            done_q     <= (state_q == ST_CHK) & accept;
            if (state_q == ST_IDLE) begin
                if (start_ok) begin
                    tag_q <= io.frm_tag;
                    len_q <= io.frm_len;
                    cnt_q <= (io.frm_len == 8'd0) ? 9'd256 : {1'b0, io.frm_len};
                    acc_q <= '0;
                end
            end else if (accept && state_q != ST_SYNC && state_q != ST_CHK) begin
                acc_q <= acc_upd(acc_q, d_q);
                if (state_q == ST_DHI) cnt_q <= cnt_q - 9'd1;
            end
        end
    end

    assign io.frm_busy = busy;
    assign io.frm_done = done_q;
    assign io.s_ready  = ~fifo_full;
    assign io.bus_req  = busy;
    assign io.ft_wr_n  = ~accept;
    assign io.ft_d_out = d_q;
    assign io.ft_d_oe  = io.bus_gnt & busy;
endmodule

// File: tb/tb_ftdi_tx_framer.sv
// Scoreboard bench for ftdi_tx_framer: random frames/words against a byte-level frame model.
// Define FTDI_TX_CRC_EN for both RTL and bench to exercise the CRC-8 check byte.
module tb_ftdi_tx_framer;
    import ftdi_tx_pkg::*;

    logic ft_clk = 1'b0;
    logic reset_n = 1'b0;

    ftdi_tx_framer_if bus ();

    ftdi_tx_framer #(.FIFO_AW(4), .SYNC_BYTE(8'hA5)) dut (
        .ft_clk  (ft_clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    always #5 ft_clk = ~ft_clk;

    typedef struct {
        logic [7:0] tag;
        logic [7:0] len;
    } frame_t;

    int          total = 0;
    int          bad   = 0;
    frame_t      frm_q[$];
    logic [15:0] word_q[$];
    bit          txe_rand = 1'b0;
    bit          strict_span = 1'b0;

    // monitor state
    int          mon_idx = 0;
    frame_t      cur;
    int          nwords = 0;
    logic [15:0] curw = '0;
    logic [7:0]  body[$];
    bit          expect_done = 1'b0;
    int          cyc = 0;
    int          first_cyc = 0;
    logic [7:0]  exp_b;
    int          k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_check(input logic [7:0] b[$]);
        logic [7:0] c;
        int         s;
        bit         fb;
        c = 8'h00;
        s = 0;
        foreach (b[i]) begin
            s += int'(b[i]);
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ b[i][j];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
`ifdef FTDI_TX_CRC_EN
        return c;
`else
        return 8'((256 - (s % 256)) % 256);
`endif
    endfunction

    // TXE# source: low unless the random mode is on
    always @(posedge ft_clk) begin
        #1;
        bus.ft_txe_n = txe_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    end

    // Monitor: every byte strobed out is popped against the frame model
    always @(negedge ft_clk) begin
        cyc++;
        if (!reset_n) begin
            mon_idx     = 0;
            expect_done = 1'b0;
            body.delete();
        end else begin
            if (expect_done) chk("frm_done", bus.frm_done, 1);
            else             chk("frm_done_idle", bus.frm_done, 0);
            expect_done = 1'b0;
            if (bus.ft_txe_n !== 1'b0 || bus.bus_gnt !== 1'b1) chk("wr_n_blocked", bus.ft_wr_n, 1);
            if (bus.bus_gnt === 1'b0) chk("oe_off", bus.ft_d_oe, 0);
            if (bus.ft_wr_n === 1'b0) begin
                if (mon_idx == 0 && frm_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected no frame", bus.ft_d_out);
                end else begin
                    if (mon_idx == 0) begin
                        cur       = frm_q.pop_front();
                        nwords    = (cur.len == 8'd0) ? 256 : int'(cur.len);
                        first_cyc = cyc;
                        body.delete();
                    end
                    k = mon_idx - 3;
                    if (mon_idx == 0)      exp_b = 8'hA5;
                    else if (mon_idx == 1) exp_b = cur.tag;
                    else if (mon_idx == 2) exp_b = cur.len;
                    else if (k < 2 * nwords) begin
                        if (k % 2 == 0) begin
                            if (word_q.size() == 0) curw = 16'hxxxx;
                            else                    curw = word_q.pop_front();
                            exp_b = curw[7:0];
                        end else begin
                            exp_b = curw[15:8];
                        end
                    end else begin
                        exp_b = ref_check(body);
                    end
                    chk($sformatf("byte%0d", mon_idx), bus.ft_d_out, exp_b);
                    if (mon_idx >= 1 && k < 2 * nwords) body.push_back(exp_b);
                    if (k == 2 * nwords) begin
                        if (strict_span) chk("span", cyc - first_cyc, 2 * nwords + 3);
                        mon_idx     = 0;
                        expect_done = 1'b1;
                    end else begin
                        mon_idx++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge ft_clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        for (int i = 0; i < 400; i++) begin
            @(negedge ft_clk);
            if (bus.s_ready === 1'b1) begin
                word_q.push_back(w);
                step();
                bus.s_valid = 1'b0;
                return;
            end
            step();
        end
        bus.s_valid = 1'b0;
        total++;
        bad++;
        $display("FAIL push_timeout: got s_ready=0 expected 1 within 400 cycles");
    endtask

    task automatic start_frame(input logic [7:0] tag, input logic [7:0] len);
        frame_t f;
        for (int i = 0; i < 3000 && (bus.frm_busy !== 1'b0 || bus.frm_done !== 1'b0); i++) step();
        chk("start_idle", bus.frm_busy, 0);
        bus.frm_start = 1'b1;
        bus.frm_tag   = tag;
        bus.frm_len   = len;
        f.tag = tag;
        f.len = len;
        frm_q.push_back(f);
        step();
        bus.frm_start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (frm_q.size() == 0 && mon_idx == 0 && !expect_done && bus.frm_busy === 1'b0) break;
            step();
        end
        if (i == limit) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: got busy=%0b pending=%0d expected idle", bus.frm_busy, frm_q.size());
        end
    endtask

    task automatic wait_idx(input int target);
        int i;
        for (i = 0; i < 500 && mon_idx != target; i++) step();
        if (i == 500) begin
            total++;
            bad++;
            $display("FAIL idx_timeout: got idx=%0d expected %0d", mon_idx, target);
        end
    endtask

    task automatic reset_vals(input string tagname);
        chk({tagname, "_busy"},  bus.frm_busy, 0);
        chk({tagname, "_done"},  bus.frm_done, 0);
        chk({tagname, "_ready"}, bus.s_ready, 1);
        chk({tagname, "_req"},   bus.bus_req, 0);
        chk({tagname, "_wr_n"},  bus.ft_wr_n, 1);
        chk({tagname, "_dout"},  bus.ft_d_out, 0);
        chk({tagname, "_oe"},    bus.ft_d_oe, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before 900us");
        $fatal(1);
    end

    initial begin
        int n;
        bus.frm_start = 1'b0;
        bus.frm_len   = '0;
        bus.frm_tag   = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.bus_gnt   = 1'b1;
        reset_n       = 1'b0;
        repeat (3) step();
        reset_vals("rst");
        reset_n = 1'b1;
        step();

        // basic frame, no stalls: bytes on consecutive cycles
        strict_span = 1'b1;
        push_word(16'h3412);
        start_frame(8'h10, 8'h01);
        wait_idle(200);
        strict_span = 1'b0;

        // same frame with TXE# toggling
        txe_rand = 1'b1;
        push_word(16'h3412);
        start_frame(8'h10, 8'h01);
        wait_idle(500);

        // random frames, occasional surplus word carried into the next frame
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(1, 5);
            for (int w = 0; w < n; w++) push_word(16'($urandom));
            if ($urandom_range(0, 1) == 1) push_word(16'($urandom));
            start_frame(8'($urandom), 8'(n));
            wait_idle(1000);
        end
        txe_rand = 1'b0;

        // grant dropped for 5 cycles after LEN, stray start while busy
        push_word(16'hBEEF);
        push_word(16'h0102);
        start_frame(8'h5A, 8'h02);
        wait_idx(3);
        bus.bus_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.frm_start = (i == 1);
            bus.frm_tag   = 8'hEE;
            bus.frm_len   = 8'h01;
            step();
            chk("gap_req", bus.bus_req, 1);
            chk("gap_oe", bus.ft_d_oe, 0);
        end
        bus.frm_start = 1'b0;
        bus.bus_gnt   = 1'b1;
        wait_idle(500);

        // 256-word frame: fill FIFO to full, then feed with gaps
        n = 16 - word_q.size();
        for (int i = 0; i < n; i++) push_word(16'($urandom));
        @(negedge ft_clk);
        chk("full_ready", bus.s_ready, 0);
        step();
        start_frame(8'hC3, 8'h00);
        for (int i = 0; i < 244; i++) begin
            repeat ($urandom_range(0, 3)) step();
            push_word(16'($urandom));
        end
        wait_idle(3000);
        start_frame(8'h44, 8'd4);
        wait_idle(500);

        // reset asserted while the high byte is pending
        for (int i = 0; i < 3; i++) push_word(16'($urandom));
        start_frame(8'h77, 8'h03);
        wait_idx(4);
        reset_n = 1'b0;
        frm_q.delete();
        word_q.delete();
        step();
        reset_vals("abort");
        step();
        reset_n = 1'b1;
        step();
        push_word(16'hA0B1);
        start_frame(8'h21, 8'h01);
        wait_idle(200);

`ifdef FTDI_TX_CRC_EN
        begin
            logic [7:0] c;
            string      s;
            s = "123456789";
            c = 8'h00;
            for (int i = 0; i < s.len(); i++) c = crc8_byte(c, s[i]);
            chk("crc8_check", c, 8'hF4);
        end
`endif

        repeat (10) step();
        chk("end_busy", bus.frm_busy, 0);
        chk("end_ready", bus.s_ready, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
